logic_avalon_mm_arbiter: RTL and testbench
==========================================

Name: logic_avalon_mm_arbiter

Overview:
- Shares one Avalon-MM slave between MASTERS Avalon-MM masters using round-robin arbitration.
- Forwards one transfer per grant.
- Records the issuing master of every accepted read and write in in-order ID FIFOs, so that readdatavalid and writeresponsevalid are routed back to the correct master.
- Sits between CPU/DMA-style masters and a shared register or memory slave.

Parameters:
MASTERS, 2, number of masters; range 2..16
DATA_BYTES, 4, bytes in writedata/readdata; power of 2, range 1..128
ADDRESS_WIDTH, 1, address bits; range 1..64
MAX_PENDING, 8, depth of each ID FIFO (outstanding reads / outstanding writes); power of 2, range 2..64

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
m_read  input  MASTERS  per-master read request
m_write  input  MASTERS  per-master write request
m_address  input  MASTERS x ADDRESS_WIDTH  per-master address
m_writedata  input  MASTERS x DATA_BYTES*8  per-master write data
m_byteenable  input  MASTERS x DATA_BYTES  per-master byte enables
m_waitrequest  output  MASTERS  per-master stall
m_readdata  output  DATA_BYTES*8  shared read data, qualified by m_readdatavalid
m_response  output  2  shared response code (logic_avalon_mm_pkg::response_t)
m_readdatavalid  output  MASTERS  one-hot read data valid
m_writeresponsevalid  output  MASTERS  one-hot write response valid
s_read  output  1  slave read
s_write  output  1  slave write
s_address  output  ADDRESS_WIDTH  slave address
s_writedata  output  DATA_BYTES*8  slave write data
s_byteenable  output  DATA_BYTES  slave byte enables
s_waitrequest  input  1  slave stall
s_readdata  input  DATA_BYTES*8  slave read data
s_response  input  2  slave response code
s_readdatavalid  input  1  slave read data valid
s_writeresponsevalid  input  1  slave write response valid
error  output  1  one-cycle pulse: a response arrived with no matching pending ID

Behaviour:
- Clock and reset: single clock domain (clk). Reset is synchronous and active-high.
- FSM states: IDLE, GRANTED.
- Grant registers: grant (one-hot) and last (index of the previous winner).
- IDLE:
  - If any m_read|m_write is set, register the winner as the first requester after last, scanning upward with wrap-around.
  - Update last and go to GRANTED.
  - Arbitration latency: 1 cycle.
- GRANTED, forwarding:
  - The granted master's read/write/address/writedata/byteenable drive s_*.
  - s_read/s_write are gated to 0 if the corresponding ID FIFO is full.
- GRANTED, waitrequest:
  - Granted master: m_waitrequest = s_waitrequest | (target FIFO full).
  - All other masters: m_waitrequest = 1.
- GRANTED, acceptance: a transfer is accepted when the forwarded s_read or s_write is 1 and s_waitrequest is 0.
  - Accepted read: push the master index into the read FIFO.
  - Accepted write: push the master index into the write FIFO.
  - Return to IDLE.
  - Maximum throughput: 1 transfer per 2 cycles.
- GRANTED with the granted master showing neither read nor write: return to IDLE, no push.
- Granted master asserting read and write together: read has priority; write is ignored for that grant.
- Read responses:
  - s_readdatavalid pops the read FIFO head.
  - m_readdatavalid[head] = 1 in the same cycle, combinationally.
  - m_readdata = s_readdata and m_response = s_response, shared across masters.
- Write responses: s_writeresponsevalid pops the write FIFO head the same way and drives m_writeresponsevalid.
- Response with an empty FIFO: the response is dropped, all valid outputs stay 0, and error pulses for 1 cycle.
- Simultaneous push and pop on the same FIFO: both take effect.
  - Occupancy is unchanged.
  - When full, the pop does not enable a same-cycle push; full is computed from registered occupancy.
- Pointer wrap: FIFO pointers are log2(MAX_PENDING) bits and wrap naturally; occupancy counters are log2(MAX_PENDING)+1 bits.
- Reset values: state = IDLE, grant = 0, last = MASTERS-1 (master 0 wins first), FIFOs empty, error = 0.
  - Resulting outputs: all m_waitrequest = 1, s_read = s_write = 0, all m_readdatavalid = 0, all m_writeresponsevalid = 0.
- Reset mid-transfer: pending IDs are discarded. Any later slave responses raise error and are not routed.
- Design rule checks: parameter ranges enforced with the LOGIC_DRC macros.

Test Plan:
- Single master write: masters 0/1 idle, then m_write[1]=1 at addr 0x1. Grant in cycle 1, s_write=1 cycle 1, s_waitrequest=0, m_waitrequest[1]=0 cycle 1. Write FIFO holds 1. s_writeresponsevalid then gives m_writeresponsevalid=2'b10.
- Fairness: both masters continuously request reads with MASTERS=2. Slave accepts order 0,1,0,1. Each m_waitrequest stays 1 while the other is granted.
- Interleaved read return: master 0 reads addr 0, then master 1 reads addr 1. Slave returns 0xAAAA then 0xBBBB. m_readdatavalid = 01 with 0xAAAA, then 10 with 0xBBBB.
- Backpressure: s_waitrequest=1 for 3 cycles during a grant. s_* stays stable, the grant is held, there is no push, and the transfer is accepted on cycle 4.
- FIFO full: MAX_PENDING=2 with 2 reads outstanding, and a third read is requested. s_read=0 and m_waitrequest=1 until s_readdatavalid pops. The read is then issued and routed correctly.
- Orphan/reset: assert reset with 1 read pending, then drive s_readdatavalid=1. error pulses once, all m_readdatavalid=0, all m_waitrequest=1 during reset.

Source files
------------

// File: rtl/logic_avalon_mm_arbiter_if.sv
// Avalon-MM bundle: PORTS request lanes plus one shared read-data/response lane.
// The arbiter uses the slave modport toward its masters and the master modport toward the slave.
interface logic_avalon_mm_arbiter_if #(
  parameter int PORTS         = 1,
  parameter int DATA_BYTES    = 4,
  parameter int ADDRESS_WIDTH = 1
);
  logic [PORTS-1:0]                    read;
  logic [PORTS-1:0]                    write;
  logic [PORTS-1:0][ADDRESS_WIDTH-1:0] address;
  logic [PORTS-1:0][DATA_BYTES*8-1:0]  writedata;
  logic [PORTS-1:0][DATA_BYTES-1:0]    byteenable;
  logic [PORTS-1:0]                    waitrequest;
  logic [DATA_BYTES*8-1:0]             readdata;
  logic [1:0]                          response;
  logic [PORTS-1:0]                    readdatavalid;
  logic [PORTS-1:0]                    writeresponsevalid;

  modport master (
    output read, write, address, writedata, byteenable,
    input  waitrequest, readdata, response, readdatavalid, writeresponsevalid
  );

  modport slave (
    input  read, write, address, writedata, byteenable,
    output waitrequest, readdata, response, readdatavalid, writeresponsevalid
  );
endinterface

// File: rtl/logic_avalon_mm_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave between MASTERS masters.
// In-order ID FIFOs route read data and write responses back to the issuing master.

`ifndef LOGIC_DRC
`define LOGIC_DRC(label, cond, msg) if (!(cond)) begin : label $error(msg); end
`endif

module logic_avalon_mm_arbiter #(
  parameter int MASTERS       = 2,
  parameter int DATA_BYTES    = 4,
  parameter int ADDRESS_WIDTH = 1,
  parameter int MAX_PENDING   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  logic_avalon_mm_arbiter_if.slave  m_bus,
  logic_avalon_mm_arbiter_if.master s_bus,
  output logic                      error
);
  localparam int          IW    = $clog2(MASTERS);
  localparam int          PW    = $clog2(MAX_PENDING);
  localparam logic [IW:0] NUM_M = MASTERS[IW:0];
  localparam logic [PW:0] DEPTH = MAX_PENDING[PW:0];

  `LOGIC_DRC(drc_masters, (MASTERS >= 2) && (MASTERS <= 16), "MASTERS must be in 2..16")
  `LOGIC_DRC(drc_data_bytes, (DATA_BYTES >= 1) && (DATA_BYTES <= 128) && ((DATA_BYTES & (DATA_BYTES - 1)) == 0), "DATA_BYTES must be a power of 2 in 1..128")
  `LOGIC_DRC(drc_address_width, (ADDRESS_WIDTH >= 1) && (ADDRESS_WIDTH <= 64), "ADDRESS_WIDTH must be in 1..64")
  `LOGIC_DRC(drc_max_pending, (MAX_PENDING >= 2) && (MAX_PENDING <= 64) && ((MAX_PENDING & (MAX_PENDING - 1)) == 0), "MAX_PENDING must be a power of 2 in 2..64")

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t             state_q, state_d;
  logic [MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]      last_q, last_d;
  logic               error_q, error_d;

  logic [IW-1:0] rd_mem_q [MAX_PENDING];
  logic [IW-1:0] wr_mem_q [MAX_PENDING];
  logic [PW-1:0] rd_wptr_q, rd_wptr_d, rd_rptr_q, rd_rptr_d;
  logic [PW-1:0] wr_wptr_q, wr_wptr_d, wr_rptr_q, wr_rptr_d;
  logic [PW:0]   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  logic          rd_full, wr_full, rd_empty, wr_empty;
  logic          rd_push, wr_push, rd_pop, wr_pop;
  logic          g_read, g_write, fwd_read, fwd_write, accept;
  logic [IW-1:0] winner;
  logic [IW:0]   cand;
  logic          found;

  assign rd_full  = (rd_cnt_q == DEPTH);
  assign wr_full  = (wr_cnt_q == DEPTH);
  assign rd_empty = (rd_cnt_q == '0);
  assign wr_empty = (wr_cnt_q == '0);
  assign error    = error_q;

  // First requester strictly after last, wrapping past MASTERS-1.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= MASTERS; i++) begin
      cand = {1'b0, last_q} + (IW+1)'(i);
      if (cand >= NUM_M) begin
        cand = cand - NUM_M;
      end
      if (!found && (m_bus.read[cand[IW-1:0]] || m_bus.write[cand[IW-1:0]])) begin
        winner = cand[IW-1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    last_d            = last_q;
    rd_push           = 1'b0;
    wr_push           = 1'b0;
    fwd_read          = 1'b0;
    fwd_write         = 1'b0;
    accept            = 1'b0;
    s_bus.read        = '0;
    s_bus.write       = '0;
    s_bus.address     = '0;
    s_bus.writedata   = '0;
    s_bus.byteenable  = '0;
    m_bus.waitrequest = '1;
    // Read wins when a master raises both strobes in the same grant.
    g_read            = m_bus.read[last_q];
    g_write           = m_bus.write[last_q] && !g_read;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          last_d          = winner;
          state_d         = GRANTED;
        end
      end
      GRANTED: begin
        fwd_read            = g_read && !rd_full;
        fwd_write           = g_write && !wr_full;
        s_bus.read[0]       = fwd_read;
        s_bus.write[0]      = fwd_write;
        s_bus.address[0]    = m_bus.address[last_q];
        s_bus.writedata[0]  = m_bus.writedata[last_q];
        s_bus.byteenable[0] = m_bus.byteenable[last_q];
        m_bus.waitrequest   = ~grant_q |
            {MASTERS{s_bus.waitrequest[0] || (g_read && rd_full) || (g_write && wr_full)}};
        accept  = (fwd_read || fwd_write) && !s_bus.waitrequest[0];
        rd_push = accept && fwd_read;
        wr_push = accept && fwd_write;
        if (accept || (!g_read && !g_write)) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (reset) begin
      s_bus.read        = '0;
      s_bus.write       = '0;
      m_bus.waitrequest = '1;
      rd_push           = 1'b0;
      wr_push           = 1'b0;
    end
  end

  always_comb begin
    rd_pop                   = s_bus.readdatavalid[0] && !rd_empty && !reset;
    wr_pop                   = s_bus.writeresponsevalid[0] && !wr_empty && !reset;
    m_bus.readdatavalid      = '0;
    m_bus.writeresponsevalid = '0;
    if (rd_pop) begin
      m_bus.readdatavalid[rd_mem_q[rd_rptr_q]] = 1'b1;
    end
    if (wr_pop) begin
      m_bus.writeresponsevalid[wr_mem_q[wr_rptr_q]] = 1'b1;
    end
    m_bus.readdata = s_bus.readdata;
    m_bus.response = s_bus.response;
    error_d = !reset && ((s_bus.readdatavalid[0] && rd_empty) ||
                         (s_bus.writeresponsevalid[0] && wr_empty));

    rd_wptr_d = rd_wptr_q + PW'(rd_push);
    rd_rptr_d = rd_rptr_q + PW'(rd_pop);
    rd_cnt_d  = rd_cnt_q + (PW+1)'(rd_push) - (PW+1)'(rd_pop);
    wr_wptr_d = wr_wptr_q + PW'(wr_push);
    wr_rptr_d = wr_rptr_q + PW'(wr_pop);
    wr_cnt_d  = wr_cnt_q + (PW+1)'(wr_push) - (PW+1)'(wr_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= IW'(MASTERS - 1);
      error_q   <= 1'b0;
      rd_wptr_q <= '0;
      rd_rptr_q <= '0;
      rd_cnt_q  <= '0;
      wr_wptr_q <= '0;
      wr_rptr_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      error_q   <= error_d;
      rd_wptr_q <= rd_wptr_d;
      rd_rptr_q <= rd_rptr_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_wptr_q <= wr_wptr_d;
      wr_rptr_q <= wr_rptr_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  // ID storage needs no reset: occupancy counters define which entries are live.
  always_ff @(posedge clk) begin
    if (rd_push) begin
      rd_mem_q[rd_wptr_q] <= last_q;
    end
    if (wr_push) begin
      wr_mem_q[wr_wptr_q] <= last_q;
    end
  end
endmodule

// File: tb/tb_logic_avalon_mm_arbiter.sv
// Scoreboard bench for the two-master arbiter with two-deep ID FIFOs.
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_logic_avalon_mm_arbiter;
  localparam int M  = 2;
  localparam int DB = 4;
  localparam int DW = DB * 8;
  localparam int AW = 4;
  localparam int MP = 2;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DB-1:0] be;
  } req_t;

  typedef struct packed {
    logic [M-1:0]  wreq;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DB-1:0] be;
  } slv_t;

  typedef struct packed {
    logic [M-1:0]  vld;
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  logic error;
  int   checks   = 0;
  int   failures = 0;
  int   acc_cnt  = 0;
  int   exp_err  = 0;

  req_t mq0[$];
  req_t mq1[$];
  slv_t exp_slv[$];
  rsp_t exp_rd[$];
  rsp_t exp_wr[$];

  logic_avalon_mm_arbiter_if #(.PORTS(M), .DATA_BYTES(DB), .ADDRESS_WIDTH(AW)) m_bus();
  logic_avalon_mm_arbiter_if #(.PORTS(1), .DATA_BYTES(DB), .ADDRESS_WIDTH(AW)) s_bus();

  logic_avalon_mm_arbiter #(
    .MASTERS(M), .DATA_BYTES(DB), .ADDRESS_WIDTH(AW), .MAX_PENDING(MP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .m_bus (m_bus),
    .s_bus (s_bus),
    .error (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Master driver: holds each queued request until the arbiter drops waitrequest.
  initial begin
    m_bus.read       = '0;
    m_bus.write      = '0;
    m_bus.address    = '0;
    m_bus.writedata  = '0;
    m_bus.byteenable = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mq0.size() > 0) begin
        m_bus.read[0]       = mq0[0].rd;
        m_bus.write[0]      = mq0[0].wr;
        m_bus.address[0]    = mq0[0].addr;
        m_bus.writedata[0]  = mq0[0].data;
        m_bus.byteenable[0] = mq0[0].be;
      end else begin
        m_bus.read[0]  = 1'b0;
        m_bus.write[0] = 1'b0;
      end
      if (mq1.size() > 0) begin
        m_bus.read[1]       = mq1[0].rd;
        m_bus.write[1]      = mq1[0].wr;
        m_bus.address[1]    = mq1[0].addr;
        m_bus.writedata[1]  = mq1[0].data;
        m_bus.byteenable[1] = mq1[0].be;
      end else begin
        m_bus.read[1]  = 1'b0;
        m_bus.write[1] = 1'b0;
      end
      @(negedge clk);
      if ((m_bus.read[0] || m_bus.write[0]) && !m_bus.waitrequest[0] && !reset)
        void'(mq0.pop_front());
      if ((m_bus.read[1] || m_bus.write[1]) && !m_bus.waitrequest[1] && !reset)
        void'(mq1.pop_front());
    end
  end

  // Monitor: every DUT-presented event consumes one expectation.
  always @(negedge clk) begin
    slv_t es;
    rsp_t er;
    if ((s_bus.read[0] || s_bus.write[0]) && !s_bus.waitrequest[0]) begin
      acc_cnt++;
      if (exp_slv.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL slv_unexpected: got rd=%b wr=%b addr=%h with no transfer expected",
                 s_bus.read[0], s_bus.write[0], s_bus.address[0]);
      end else begin
        es = exp_slv.pop_front();
        chk("slv_xfer", {s_bus.read[0], s_bus.write[0], s_bus.address[0], s_bus.writedata[0],
                         s_bus.byteenable[0], m_bus.waitrequest},
                        {es.rd, es.wr, es.addr, es.data, es.be, es.wreq});
      end
    end
    if (m_bus.readdatavalid != '0) begin
      if (exp_rd.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got readdatavalid=%b expected none", m_bus.readdatavalid);
      end else begin
        er = exp_rd.pop_front();
        chk("rd_return", {m_bus.readdatavalid, m_bus.readdata, m_bus.response},
                         {er.vld, er.data, er.resp});
      end
    end
    if (m_bus.writeresponsevalid != '0) begin
      if (exp_wr.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_unexpected: got writeresponsevalid=%b expected none",
                 m_bus.writeresponsevalid);
      end else begin
        er = exp_wr.pop_front();
        chk("wr_return", {m_bus.writeresponsevalid, m_bus.response}, {er.vld, er.resp});
      end
    end
    if (error === 1'b1) begin
      if (exp_err == 0) begin
        checks++;
        failures++;
        $display("FAIL error_unexpected: got error=1 expected 0");
      end else begin
        exp_err--;
        chk("error_pulse", error, 1);
      end
    end
  end

  task automatic wait_accepts(input int n);
    int k = 0;
    while (acc_cnt < n && k < 300) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (acc_cnt < n) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got %0d accepts required %0d", acc_cnt, n);
    end
  endtask

  task automatic slv_rd(input logic [DW-1:0] d, input logic [1:0] r);
    s_bus.readdatavalid[0] = 1'b1;
    s_bus.readdata         = d;
    s_bus.response         = r;
    @(posedge clk);
    #1;
    s_bus.readdatavalid[0] = 1'b0;
  endtask

  task automatic slv_wr(input logic [1:0] r);
    s_bus.writeresponsevalid[0] = 1'b1;
    s_bus.response              = r;
    @(posedge clk);
    #1;
    s_bus.writeresponsevalid[0] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset                       = 1'b1;
    s_bus.waitrequest           = '0;
    s_bus.readdata              = '0;
    s_bus.response              = '0;
    s_bus.readdatavalid         = '0;
    s_bus.writeresponsevalid    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_waitreq", m_bus.waitrequest, 2'b11);
    chk("rst_s_rdwr", {s_bus.read[0], s_bus.write[0]}, 2'b00);
    chk("rst_valids", {m_bus.readdatavalid, m_bus.writeresponsevalid}, 4'b0000);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_waitreq", m_bus.waitrequest, 2'b11);
    chk("idle_error", error, 0);
    @(posedge clk);
    #1;

    // Single master write from master 1.
    mq1.push_back('{rd: 1'b0, wr: 1'b1, addr: 4'h1, data: 32'hDEADBEEF, be: 4'hF});
    exp_slv.push_back('{wreq: 2'b01, rd: 1'b0, wr: 1'b1, addr: 4'h1, data: 32'hDEADBEEF, be: 4'hF});
    wait_accepts(1);
    exp_wr.push_back('{vld: 2'b10, data: '0, resp: 2'b00});
    slv_wr(2'b00);

    // Both masters read twice: order 0,1,0,1 with the FIFO filling after two.
    mq0.push_back('{rd: 1'b1, wr: 1'b0, addr: 4'h0, data: '0, be: 4'hF});
    mq0.push_back('{rd: 1'b1, wr: 1'b0, addr: 4'h2, data: '0, be: 4'hF});
    mq1.push_back('{rd: 1'b1, wr: 1'b0, addr: 4'h1, data: '0, be: 4'hF});
    mq1.push_back('{rd: 1'b1, wr: 1'b0, addr: 4'h3, data: '0, be: 4'hF});
    exp_slv.push_back('{wreq: 2'b10, rd: 1'b1, wr: 1'b0, addr: 4'h0, data: '0, be: 4'hF});
    exp_slv.push_back('{wreq: 2'b01, rd: 1'b1, wr: 1'b0, addr: 4'h1, data: '0, be: 4'hF});
    exp_slv.push_back('{wreq: 2'b10, rd: 1'b1, wr: 1'b0, addr: 4'h2, data: '0, be: 4'hF});
    exp_slv.push_back('{wreq: 2'b01, rd: 1'b1, wr: 1'b0, addr: 4'h3, data: '0, be: 4'hF});
    wait_accepts(3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_s_read", s_bus.read[0], 0);
      chk("full_waitreq", m_bus.waitrequest, 2'b11);
    end
    chk("full_no_accept", acc_cnt, 3);
    @(posedge clk);
    #1;
    exp_rd.push_back('{vld: 2'b01, data: 32'h0000AAAA, resp: 2'b00});
    slv_rd(32'h0000AAAA, 2'b00);
    wait_accepts(4);
    exp_rd.push_back('{vld: 2'b10, data: 32'h0000BBBB, resp: 2'b00});
    slv_rd(32'h0000BBBB, 2'b00);
    wait_accepts(5);
    exp_rd.push_back('{vld: 2'b01, data: 32'h00001111, resp: 2'b10});
    slv_rd(32'h00001111, 2'b10);
    exp_rd.push_back('{vld: 2'b10, data: 32'h00002222, resp: 2'b00});
    slv_rd(32'h00002222, 2'b00);

    // Slave backpressure for three cycles during a write grant.
    s_bus.waitrequest[0] = 1'b1;
    mq0.push_back('{rd: 1'b0, wr: 1'b1, addr: 4'h5, data: 32'hCAFEF00D, be: 4'b0011});
    exp_slv.push_back('{wreq: 2'b10, rd: 1'b0, wr: 1'b1, addr: 4'h5, data: 32'hCAFEF00D, be: 4'b0011});
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!s_bus.write[0] && k < 50);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_hold", {s_bus.write[0], s_bus.address[0], s_bus.writedata[0], s_bus.byteenable[0]},
                     {1'b1, 4'h5, 32'hCAFEF00D, 4'b0011});
      chk("bp_waitreq", m_bus.waitrequest, 2'b11);
      chk("bp_no_accept", acc_cnt, 5);
    end
    @(posedge clk);
    #1 s_bus.waitrequest[0] = 1'b0;
    wait_accepts(6);
    exp_wr.push_back('{vld: 2'b01, data: '0, resp: 2'b01});
    slv_wr(2'b01);

    // Read and write together: read wins, no write ID recorded.
    mq1.push_back('{rd: 1'b1, wr: 1'b1, addr: 4'h7, data: 32'h00000055, be: 4'hF});
    exp_slv.push_back('{wreq: 2'b01, rd: 1'b1, wr: 1'b0, addr: 4'h7, data: 32'h00000055, be: 4'hF});
    wait_accepts(7);
    exp_rd.push_back('{vld: 2'b10, data: 32'h00003333, resp: 2'b10});
    slv_rd(32'h00003333, 2'b10);
    exp_err++;
    slv_wr(2'b00);
    repeat (2) @(posedge clk);
    #1;

    // Reset with one read pending: the later response is an orphan.
    mq0.push_back('{rd: 1'b1, wr: 1'b0, addr: 4'h9, data: '0, be: 4'hF});
    exp_slv.push_back('{wreq: 2'b10, rd: 1'b1, wr: 1'b0, addr: 4'h9, data: '0, be: 4'hF});
    wait_accepts(8);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_mid_waitreq", m_bus.waitrequest, 2'b11);
      chk("rst_mid_outputs", {s_bus.read[0], s_bus.write[0], m_bus.readdatavalid}, 4'b0000);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    exp_err++;
    s_bus.readdatavalid[0] = 1'b1;
    s_bus.readdata         = 32'h00004444;
    @(negedge clk);
    chk("orphan_rdv", m_bus.readdatavalid, 2'b00);
    @(posedge clk);
    #1 s_bus.readdatavalid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    chk("end_exp_slv", exp_slv.size(), 0);
    chk("end_exp_rd", exp_rd.size(), 0);
    chk("end_exp_wr", exp_wr.size(), 0);
    chk("end_exp_err", exp_err, 0);
    chk("end_accepts", acc_cnt, 8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
